// File: rtl/jelly_uart_rx_ctrl.sv
// UART receiver: 2-FF input synchronizer, programmable 8x oversample prescaler,
// start/data/stop sequencer with glitch and break handling, and a byte FIFO.
module jelly_uart_rx_ctrl #(
    parameter int DIV_WIDTH      = 16,
    parameter int FIFO_PTR_WIDTH = 4
) (
    input  logic                      reset,
    input  logic                      clk,
    input  logic                      cfg_enable,
    input  logic [DIV_WIDTH-1:0]      cfg_div,
    input  logic                      uart_rx,
    output logic [7:0]                m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [FIFO_PTR_WIDTH:0]   fifo_count,
    output logic                      status_overrun,
    output logic                      status_frame_err,
    input  logic                      status_clear
);

    localparam int DEPTH = 1 << FIFO_PTR_WIDTH;
    localparam logic [FIFO_PTR_WIDTH:0] DEPTH_CNT = (FIFO_PTR_WIDTH+1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    logic                      rx_meta_q;
    logic                      rx_s_q;
    logic [DIV_WIDTH-1:0]      presc_q;
    logic                      tick;
    state_t                    state_q;
    logic [2:0]                phase_q;
    logic [2:0]                bitcnt_q;
    logic [7:0]                shift_q;
    logic                      frame_err_q;
    logic                      overrun_q;
    logic [7:0]                mem [DEPTH];
    logic [FIFO_PTR_WIDTH-1:0] rd_q;
    logic [FIFO_PTR_WIDTH-1:0] wr_q;
    logic [FIFO_PTR_WIDTH:0]   count_q;
    logic                      stop_sample;
    logic                      push;
    logic                      pop;
    logic                      push_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // A new divider value is only picked up on reload, so a running bit is never stretched mid-count.
    assign tick = cfg_enable && (presc_q == '0);

    always_ff @(posedge clk) begin
        if (reset || !cfg_enable || presc_q == '0) begin
            presc_q <= cfg_div;
        end else begin
            presc_q <= presc_q - DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !cfg_enable) begin
            state_q  <= ST_IDLE;
            phase_q  <= 3'd0;
            bitcnt_q <= 3'd0;
            if (reset) shift_q <= 8'h00;
        end else if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= ST_START;
                        phase_q <= 3'd0;
                    end
                end
                ST_START: begin
                    phase_q <= phase_q + 3'd1;
                    if (phase_q == 3'd3 && rx_s_q) begin
                        state_q <= ST_IDLE;
                    end else if (phase_q == 3'd7) begin
                        state_q  <= ST_DATA;
                        bitcnt_q <= 3'd0;
                    end
                end
                ST_DATA: begin
                    phase_q <= phase_q + 3'd1;
                    if (phase_q == 3'd3) shift_q <= {rx_s_q, shift_q[7:1]};
                    if (phase_q == 3'd7) begin
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    phase_q <= phase_q + 3'd1;
                    if (phase_q == 3'd3) state_q <= rx_s_q ? ST_IDLE : ST_BREAK;
                end
                ST_BREAK: begin
                    if (rx_s_q) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stop_sample = tick && (state_q == ST_STOP) && (phase_q == 3'd3);
    assign push        = stop_sample && rx_s_q;

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign pop     = m_valid && m_ready;
    assign push_ok = push && ((count_q != DEPTH_CNT) || pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_q] <= shift_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q        <= '0;
            wr_q        <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (push_ok) wr_q <= wr_q + FIFO_PTR_WIDTH'(1);
            if (pop)     rd_q <= rd_q + FIFO_PTR_WIDTH'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + (FIFO_PTR_WIDTH+1)'(1);
                2'b01:   count_q <= count_q - (FIFO_PTR_WIDTH+1)'(1);
                default: count_q <= count_q;
            endcase
            // Set events win over a coincident clear.
            overrun_q   <= (overrun_q & ~status_clear) | (push & ~push_ok);
            frame_err_q <= (frame_err_q & ~status_clear) | (stop_sample & ~rx_s_q);
        end
    end

    assign m_data           = mem[rd_q];
    assign m_valid          = (count_q != '0);
    assign fifo_count       = count_q;
    assign status_overrun   = overrun_q;
    assign status_frame_err = frame_err_q;

endmodule

// File: tb/tb_jelly_uart_rx_ctrl.sv
// Directed bench for jelly_uart_rx_ctrl: serial frames in, scoreboard of expected bytes out.
module tb_jelly_uart_rx_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_enable;
    logic [15:0] cfg_div;
    logic        uart_rx;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  fifo_count;
    logic        status_overrun;
    logic        status_frame_err;
    logic        status_clear;

    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;
    int          bit_clks;
    int          p0;
    logic [7:0]  exp_q [$];

    jelly_uart_rx_ctrl #(.DIV_WIDTH(16), .FIFO_PTR_WIDTH(4)) dut (
        .reset            (reset),
        .clk              (clk),
        .cfg_enable       (cfg_enable),
        .cfg_div          (cfg_div),
        .uart_rx          (uart_rx),
        .m_data           (m_data),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .fifo_count       (fifo_count),
        .status_overrun   (status_overrun),
        .status_frame_err (status_frame_err),
        .status_clear     (status_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every accepted byte must match the scoreboard head; 0x100 marks an unexpected byte.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset && m_valid && m_ready) begin
            pops++;
            if (exp_q.size() == 0) e = 32'h100;
            else                   e = 32'(exp_q.pop_front());
            check("rx_byte", 32'(m_data), e);
            $display("pop: data=%02h count=%0d", m_data, fifo_count);
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        uart_rx = 1'b0;
        wait_clks(bit_clks);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            wait_clks(bit_clks);
        end
        uart_rx = stop;
        wait_clks(bit_clks);
        $display("sent: data=%02h stop=%0b", d, stop);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            wait_clks(1);
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_clear();
        status_clear = 1'b1;
        wait_clks(1);
        status_clear = 1'b0;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        cfg_enable   = 1'b1;
        cfg_div      = 16'd3;
        uart_rx      = 1'b1;
        m_ready      = 1'b1;
        status_clear = 1'b0;
        bit_clks     = 32;
        wait_clks(5);
        check("reset_m_valid",   32'(m_valid), 32'd0);
        check("reset_count",     32'(fifo_count), 32'd0);
        check("reset_overrun",   32'(status_overrun), 32'd0);
        check("reset_frame_err", 32'(status_frame_err), 32'd0);
        reset = 1'b0;
        wait_clks(10);

        // 1: single clean byte
        p0 = pops;
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b1);
        wait_clks(bit_clks);
        wait_drain("t1_drain");
        check("t1_pops",      32'(pops - p0), 32'd1);
        check("t1_frame_err", 32'(status_frame_err), 32'd0);
        check("t1_overrun",   32'(status_overrun), 32'd0);

        // 2: framing error followed by a long break, then a good byte
        p0 = pops;
        send_byte(8'hA3, 1'b0);
        wait_clks(40 * bit_clks);
        check("t2_frame_err_set", 32'(status_frame_err), 32'd1);
        check("t2_no_byte",       32'(fifo_count), 32'd0);
        uart_rx = 1'b1;
        wait_clks(2 * bit_clks);
        exp_q.push_back(8'h0F);
        send_byte(8'h0F, 1'b1);
        wait_clks(bit_clks);
        wait_drain("t2_drain");
        check("t2_pops", 32'(pops - p0), 32'd1);
        pulse_clear();
        check("t2_frame_err_clr", 32'(status_frame_err), 32'd0);

        // 3: short glitch rejected, receiver still able to take a byte
        p0 = pops;
        uart_rx = 1'b0;
        wait_clks(8);
        uart_rx = 1'b1;
        wait_clks(3 * bit_clks);
        check("t3_pops",      32'(pops - p0), 32'd0);
        check("t3_count",     32'(fifo_count), 32'd0);
        check("t3_frame_err", 32'(status_frame_err), 32'd0);
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1);
        wait_clks(bit_clks);
        wait_drain("t3_drain");

        // 4: overrun with consumer stalled
        m_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b1);
            wait_clks(bit_clks / 4);
        end
        check("t4_count_full", 32'(fifo_count), 32'd16);
        check("t4_overrun",    32'(status_overrun), 32'd1);
        m_ready = 1'b1;
        wait_drain("t4_drain");
        wait_clks(2);
        check("t4_count_empty", 32'(fifo_count), 32'd0);
        pulse_clear();
        check("t4_overrun_clr", 32'(status_overrun), 32'd0);

        // 5: push into a full FIFO in the same cycle as a pop
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'h20 + 8'(i));
            send_byte(8'h20 + 8'(i), 1'b1);
            wait_clks(bit_clks / 4);
        end
        check("t5_count_full", 32'(fifo_count), 32'd16);
        cfg_div  = 16'd0;
        bit_clks = 8;
        wait_clks(40);
        exp_q.push_back(8'h30);
        // With a tick every clock the stop sample lands 78 clocks after the start edge is driven.
        fork
            send_byte(8'h30, 1'b1);
            begin
                repeat (78) @(posedge clk);
                #1 m_ready = 1'b1;
                @(posedge clk);
                #1 m_ready = 1'b0;
            end
        join
        check("t5_count_still_full", 32'(fifo_count), 32'd16);
        check("t5_no_overrun",       32'(status_overrun), 32'd0);
        cfg_div  = 16'd3;
        bit_clks = 32;
        m_ready  = 1'b1;
        wait_drain("t5_drain");
        wait_clks(10);
        check("t5_count_empty", 32'(fifo_count), 32'd0);

        // 6: enable dropped mid-byte, partial byte discarded
        p0 = pops;
        uart_rx = 1'b0;
        wait_clks(5 * bit_clks + bit_clks / 2);
        cfg_enable = 1'b0;
        uart_rx    = 1'b1;
        wait_clks(2 * bit_clks);
        cfg_enable = 1'b1;
        wait_clks(bit_clks);
        check("t6_no_spurious", 32'(pops - p0), 32'd0);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        wait_clks(bit_clks);
        wait_drain("t6_drain");
        check("t6_pops",      32'(pops - p0), 32'd1);
        check("t6_frame_err", 32'(status_frame_err), 32'd0);
        check("t6_overrun",   32'(status_overrun), 32'd0);

        // 7: reset with a byte buffered
        m_ready = 1'b0;
        send_byte(8'h99, 1'b1);
        wait_clks(bit_clks);
        check("t7_buffered", 32'(fifo_count), 32'd1);
        reset = 1'b1;
        wait_clks(1);
        check("t7_reset_count", 32'(fifo_count), 32'd0);
        check("t7_reset_valid", 32'(m_valid), 32'd0);
        reset   = 1'b0;
        p0      = pops;
        m_ready = 1'b1;
        wait_clks(10);
        check("t7_no_pop", 32'(pops - p0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
